lsu_mem_resp: RTL and testbench

- Load/store unit back end. Consumes the MEM-group request from dispatch: pre-computed 32-bit address, 8-bit byte mask and lane-placed 64-bit write data.
- Issues the request on the 64-bit data-memory bus with a valid/ready handshake and tracks outstanding loads in order.
- Extracts the addressed byte, half-word or word from each 64-bit read response, sign- or zero-extends it, and writes it back to rd.
- It reverses the lane placement performed at dispatch.

---
 rtl/lsu_mem_resp.sv | 171 +++++++++++++++++
 tb/tb_lsu_mem_resp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_resp.sv
// lsu_mem_resp: load/store unit back end.
// Takes one MEM-group request per cycle from dispatch and drives it onto the
// 64-bit data-memory bus with a valid/ready handshake. Loads are tracked in
// issue order, and each read response is turned into a 32-bit write-back.
//
// state | meaning
// IDLE  | request register empty, bus_req_valid_o low
// HOLD  | request register full, presented on the bus until bus_req_ready_i
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req_mem_i .. misaligned_i    dispatch request (op flags, address, mask, data, rd)
//   req_ready_o                  unit can accept a request this cycle
//   bus_req_* / bus_addr_o ..    data-memory request channel
//   bus_rsp_valid_i/rdata_i      in-order read responses
//   wb_valid_o/rd_addr_o/data_o  registered load write-back
//   ld_busy_o                    loads outstanding
//   rsp_err_o                    sticky: response with nothing outstanding
module lsu_mem_resp #(
  parameter int LD_DEPTH = 2,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_mem_i,
  input  logic              mem_op_load_i,
  input  logic              mem_op_store_i,
  input  logic              mem_op_lb_i,
  input  logic              mem_op_lh_i,
  input  logic              mem_op_lw_i,
  input  logic              mem_op_lbu_i,
  input  logic              mem_op_lhu_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [7:0]        mem_wmask_i,
  input  logic [63:0]       mem_wdata_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              misaligned_i,
  output logic              req_ready_o,
  output logic              bus_req_valid_o,
  input  logic              bus_req_ready_i,
  output logic [31:0]       bus_addr_o,
  output logic              bus_we_o,
  output logic [7:0]        bus_wmask_o,
  output logic [63:0]       bus_wdata_o,
  input  logic              bus_rsp_valid_i,
  input  logic [63:0]       bus_rsp_rdata_i,
  output logic              wb_valid_o,
  output logic [REG_AW-1:0] wb_rd_addr_o,
  output logic [31:0]       wb_data_o,
  output logic              ld_busy_o,
  output logic              rsp_err_o
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] ld_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          accept, push, pop;
  logic          ld_full;

  // Load type is stored as {sign_extend, word, half}; byte when word=half=0.
  // LBU is therefore implied by the absence of the other flags.
  logic [2:0] ld_type;
  logic       ld_type_unused;
  assign ld_type        = {mem_op_lb_i | mem_op_lh_i, mem_op_lw_i, mem_op_lh_i | mem_op_lhu_i};
  assign ld_type_unused = mem_op_lbu_i;

  logic [REG_AW-1:0] fifo_rd   [LD_DEPTH];
  logic [2:0]        fifo_off  [LD_DEPTH];
  logic [2:0]        fifo_type [LD_DEPTH];

  assign ld_full     = (ld_cnt == CW'(LD_DEPTH));
  // rst_n gates the only combinational output so every output reads 0 in reset.
  assign req_ready_o = rst_n & ((state == IDLE) | bus_req_ready_i) & !(mem_op_load_i & ld_full);
  assign accept      = req_mem_i & req_ready_o & !misaligned_i;
  assign push        = accept & mem_op_load_i;
  assign pop         = bus_rsp_valid_i & (ld_cnt != '0);
  assign ld_busy_o   = (ld_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus_req_valid_o <= 1'b0;
      bus_addr_o      <= '0;
      bus_we_o        <= 1'b0;
      bus_wmask_o     <= '0;
      bus_wdata_o     <= '0;
    end else begin
      if (accept) begin
        state           <= HOLD;
        bus_req_valid_o <= 1'b1;
        bus_addr_o      <= {mem_addr_i[31:3], 3'b000};
        bus_we_o        <= mem_op_store_i;
        bus_wmask_o     <= mem_op_store_i ? mem_wmask_i : 8'h00;
        bus_wdata_o     <= mem_op_store_i ? mem_wdata_i : 64'h0;
      end else if (state == HOLD && bus_req_ready_i) begin
        state           <= IDLE;
        bus_req_valid_o <= 1'b0;
      end
    end
  end

  // Tracker storage needs no reset: ld_cnt qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= rd_addr_i;
      fifo_off[wr_ptr]  <= mem_addr_i[2:0];
      fifo_type[wr_ptr] <= ld_type;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ld_cnt    <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   ld_cnt <= ld_cnt + 1'b1;
        2'b01:   ld_cnt <= ld_cnt - 1'b1;
        default: ld_cnt <= ld_cnt;
      endcase
      if (bus_rsp_valid_i && ld_cnt == '0) rsp_err_o <= 1'b1;
    end
  end

  logic [2:0]  head_off, head_type;
  logic [63:0] sh_b, sh_h;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v, ext_data;

  assign head_off  = fifo_off[rd_ptr];
  assign head_type = fifo_type[rd_ptr];
  assign sh_b      = bus_rsp_rdata_i >> {head_off, 3'b000};
  assign sh_h      = bus_rsp_rdata_i >> {head_off[2:1], 4'b0000};
  assign byte_v    = sh_b[7:0];
  assign half_v    = sh_h[15:0];
  assign word_v    = head_off[2] ? bus_rsp_rdata_i[63:32] : bus_rsp_rdata_i[31:0];

  always_comb begin
    ext_data = word_v;
    case (head_type[1:0])
      2'b00:   ext_data = {{24{head_type[2] & byte_v[7]}}, byte_v};
      2'b01:   ext_data = {{16{head_type[2] & half_v[15]}}, half_v};
      default: ext_data = word_v;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o   <= 1'b0;
      wb_rd_addr_o <= '0;
      wb_data_o    <= '0;
    end else begin
      wb_valid_o <= pop;
      if (pop) begin
        wb_rd_addr_o <= fifo_rd[rd_ptr];
        wb_data_o    <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_resp.sv
module tb_lsu_mem_resp;

  localparam int TY_LB = 0, TY_LH = 1, TY_LW = 2, TY_LBU = 3, TY_LHU = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_mem_i, mem_op_load_i, mem_op_store_i;
  logic        mem_op_lb_i, mem_op_lh_i, mem_op_lw_i, mem_op_lbu_i, mem_op_lhu_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_wmask_i;
  logic [63:0] mem_wdata_i;
  logic [4:0]  rd_addr_i;
  logic        misaligned_i;
  logic        req_ready_o, bus_req_valid_o, bus_req_ready_i;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [7:0]  bus_wmask_o;
  logic [63:0] bus_wdata_o;
  logic        bus_rsp_valid_i;
  logic [63:0] bus_rsp_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        ld_busy_o, rsp_err_o;

  int total = 0;
  int bad   = 0;

  lsu_mem_resp #(.LD_DEPTH(2), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_mem_i(req_mem_i), .mem_op_load_i(mem_op_load_i), .mem_op_store_i(mem_op_store_i),
    .mem_op_lb_i(mem_op_lb_i), .mem_op_lh_i(mem_op_lh_i), .mem_op_lw_i(mem_op_lw_i),
    .mem_op_lbu_i(mem_op_lbu_i), .mem_op_lhu_i(mem_op_lhu_i),
    .mem_addr_i(mem_addr_i), .mem_wmask_i(mem_wmask_i), .mem_wdata_i(mem_wdata_i),
    .rd_addr_i(rd_addr_i), .misaligned_i(misaligned_i),
    .req_ready_o(req_ready_o), .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_wmask_o(bus_wmask_o), .bus_wdata_o(bus_wdata_o),
    .bus_rsp_valid_i(bus_rsp_valid_i), .bus_rsp_rdata_i(bus_rsp_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
    .ld_busy_o(ld_busy_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          ty;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_mem_i = 0; mem_op_load_i = 0; mem_op_store_i = 0;
    mem_op_lb_i = 0; mem_op_lh_i = 0; mem_op_lw_i = 0; mem_op_lbu_i = 0; mem_op_lhu_i = 0;
    mem_addr_i = 0; mem_wmask_i = 0; mem_wdata_i = 0; rd_addr_i = 0; misaligned_i = 0;
  endtask

  task automatic drive_load(input int ty, input logic [31:0] a, input logic [4:0] rd);
    idle_in();
    req_mem_i = 1; mem_op_load_i = 1;
    mem_op_lb_i  = (ty == TY_LB);
    mem_op_lh_i  = (ty == TY_LH);
    mem_op_lw_i  = (ty == TY_LW);
    mem_op_lbu_i = (ty == TY_LBU);
    mem_op_lhu_i = (ty == TY_LHU);
    mem_addr_i = a; rd_addr_i = rd;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
    idle_in();
    req_mem_i = 1; mem_op_store_i = 1;
    mem_addr_i = a; mem_wmask_i = m; mem_wdata_i = d;
  endtask

  initial begin
    int wb_seen;
    idle_in();
    bus_req_ready_i = 0; bus_rsp_valid_i = 0; bus_rsp_rdata_i = 0;
    rst_n = 0;

    vecs[0] = '{TY_LB,  32'h0000_2003, 5'd5,  64'h0000_0000_80FF_0000, 32'hFFFF_FF80};
    vecs[1] = '{TY_LBU, 32'h0000_2003, 5'd5,  64'h0000_0000_80FF_0000, 32'h0000_0080};
    vecs[2] = '{TY_LH,  32'h0000_2006, 5'd6,  64'h8001_0000_0000_0000, 32'hFFFF_8001};
    vecs[3] = '{TY_LW,  32'h0000_2004, 5'd7,  64'hDEAD_BEEF_0000_0000, 32'hDEAD_BEEF};
    vecs[4] = '{TY_LHU, 32'h0000_2002, 5'd8,  64'h0000_0000_9ABC_1234, 32'h0000_9ABC};
    vecs[5] = '{TY_LB,  32'h0000_2000, 5'd9,  64'hFFFF_FFFF_FFFF_FF7F, 32'h0000_007F};
    vecs[6] = '{TY_LW,  32'h0000_2000, 5'd10, 64'h1111_1111_8765_4321, 32'h8765_4321};
    vecs[7] = '{TY_LH,  32'h0000_2000, 5'd11, 64'h0000_0000_0000_7FFF, 32'h0000_7FFF};
    vecs[8] = '{TY_LB,  32'h0000_2007, 5'd31, 64'hFE00_0000_0000_0000, 32'hFFFF_FFFE};
    vecs[9] = '{TY_LBU, 32'h0000_2005, 5'd0,  64'h0000_AB00_0000_0000, 32'h0000_00AB};

    #3;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_bus_valid", bus_req_valid_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_ld_busy", ld_busy_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    #10 rst_n = 1;
    tick();

    // Store: posted, no write-back.
    drive_store(32'h1000_0004, 8'hF0, 64'h1234_5678_0000_0000);
    bus_req_ready_i = 1;
    #1 chk("st_req_ready", req_ready_o, 1);
    tick();
    idle_in();
    chk("st_bus_valid", bus_req_valid_o, 1);
    chk("st_bus_addr", bus_addr_o, 32'h1000_0000);
    chk("st_bus_we", bus_we_o, 1);
    chk("st_bus_wmask", bus_wmask_o, 8'hF0);
    chk("st_bus_wdata", bus_wdata_o, 64'h1234_5678_0000_0000);
    wb_seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (wb_valid_o) wb_seen++;
    end
    chk("st_no_wb", wb_seen, 0);
    chk("st_ld_busy", ld_busy_o, 0);
    chk("st_bus_idle", bus_req_valid_o, 0);

    // Table-driven loads.
    for (int i = 0; i < 10; i++) begin
      drive_load(vecs[i].ty, vecs[i].addr, vecs[i].rd);
      bus_req_ready_i = 1;
      tick();
      idle_in();
      chk($sformatf("v%0d_bus_valid", i), bus_req_valid_o, 1);
      chk($sformatf("v%0d_bus_addr", i), bus_addr_o, {vecs[i].addr[31:3], 3'b000});
      chk($sformatf("v%0d_bus_we", i), bus_we_o, 0);
      chk($sformatf("v%0d_bus_wmask", i), bus_wmask_o, 0);
      chk($sformatf("v%0d_ld_busy", i), ld_busy_o, 1);
      bus_rsp_valid_i = 1; bus_rsp_rdata_i = vecs[i].rdata;
      tick();
      bus_rsp_valid_i = 0; bus_rsp_rdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
      chk($sformatf("v%0d_wb_valid", i), wb_valid_o, 1);
      chk($sformatf("v%0d_wb_rd", i), wb_rd_addr_o, vecs[i].rd);
      chk($sformatf("v%0d_wb_data", i), wb_data_o, vecs[i].exp);
      tick();
      chk($sformatf("v%0d_wb_pulse", i), wb_valid_o, 0);
      chk($sformatf("v%0d_wb_hold", i), wb_data_o, vecs[i].exp);
      chk($sformatf("v%0d_busy_clr", i), ld_busy_o, 0);
    end

    // Backpressure, full tracker, in-order responses with pointer wrap.
    drive_load(TY_LW, 32'h0000_3000, 5'd1);
    bus_req_ready_i = 0;
    #1 chk("bp_l1_ready", req_ready_o, 1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive_store(32'h0000_3008, 8'hFF, 64'h1);
      #1;
      chk($sformatf("bp%0d_store_refused", c), req_ready_o, 0);
      chk($sformatf("bp%0d_valid", c), bus_req_valid_o, 1);
      chk($sformatf("bp%0d_addr", c), bus_addr_o, 32'h0000_3000);
      chk($sformatf("bp%0d_we", c), bus_we_o, 0);
      tick();
    end
    drive_load(TY_LW, 32'h0000_3008, 5'd2);
    bus_req_ready_i = 1;
    #1 chk("bp_l2_ready", req_ready_o, 1);
    tick();
    chk("bp_l2_valid", bus_req_valid_o, 1);
    chk("bp_l2_addr", bus_addr_o, 32'h0000_3008);
    drive_load(TY_LW, 32'h0000_3010, 5'd3);
    #1 chk("bp_l3_full_hold", req_ready_o, 0);
    tick();
    chk("bp_idle_after_l2", bus_req_valid_o, 0);
    chk("bp_l3_full_idle", req_ready_o, 0);
    bus_rsp_valid_i = 1; bus_rsp_rdata_i = 64'h0000_0000_AAAA_0001;
    tick();
    bus_rsp_valid_i = 0;
    chk("bp_r1_valid", wb_valid_o, 1);
    chk("bp_r1_rd", wb_rd_addr_o, 1);
    chk("bp_r1_data", wb_data_o, 32'hAAAA_0001);
    #1 chk("bp_l3_ready", req_ready_o, 1);
    tick();
    idle_in();
    chk("bp_l3_addr", bus_addr_o, 32'h0000_3010);
    bus_rsp_valid_i = 1; bus_rsp_rdata_i = 64'h0000_0000_BBBB_0002;
    tick();
    chk("bp_r2_rd", wb_rd_addr_o, 2);
    chk("bp_r2_data", wb_data_o, 32'hBBBB_0002);
    drive_load(TY_LW, 32'h0000_301C, 5'd4);
    bus_rsp_rdata_i = 64'h0000_0000_CCCC_0003;
    #1 chk("pp_l4_ready", req_ready_o, 1);
    tick();
    idle_in();
    mem_op_load_i = 1;
    bus_rsp_rdata_i = 64'hDDDD_0004_0000_0000;
    #1;
    chk("pp_r3_rd", wb_rd_addr_o, 3);
    chk("pp_r3_data", wb_data_o, 32'hCCCC_0003);
    chk("pp_l4_addr", bus_addr_o, 32'h0000_3018);
    chk("pp_busy", ld_busy_o, 1);
    chk("pp_cnt_unchanged", req_ready_o, 1);
    tick();
    idle_in();
    bus_rsp_valid_i = 0;
    chk("pp_r4_valid", wb_valid_o, 1);
    chk("pp_r4_rd", wb_rd_addr_o, 4);
    chk("pp_r4_data", wb_data_o, 32'hDDDD_0004);
    chk("pp_busy_clr", ld_busy_o, 0);
    tick();

    // Misaligned load is consumed silently.
    drive_load(TY_LW, 32'h0000_2002, 5'd12);
    misaligned_i = 1;
    #1 chk("mis_ready", req_ready_o, 1);
    tick();
    idle_in();
    chk("mis_no_bus", bus_req_valid_o, 0);
    chk("mis_no_push", ld_busy_o, 0);

    // Stray response.
    chk("err_before", rsp_err_o, 0);
    bus_rsp_valid_i = 1; bus_rsp_rdata_i = 64'h1;
    tick();
    bus_rsp_valid_i = 0;
    chk("err_set", rsp_err_o, 1);
    chk("err_no_wb", wb_valid_o, 0);
    tick(); tick();
    chk("err_sticky", rsp_err_o, 1);

    // Reset while a load is held on the bus.
    drive_load(TY_LW, 32'h0000_4000, 5'd13);
    bus_req_ready_i = 0;
    tick();
    idle_in();
    chk("mr_valid_before", bus_req_valid_o, 1);
    #2 rst_n = 0;
    #1;
    chk("mr_req_ready", req_ready_o, 0);
    chk("mr_bus_valid", bus_req_valid_o, 0);
    chk("mr_bus_addr", bus_addr_o, 0);
    chk("mr_wb_rd", wb_rd_addr_o, 0);
    chk("mr_wb_data", wb_data_o, 0);
    chk("mr_ld_busy", ld_busy_o, 0);
    chk("mr_rsp_err", rsp_err_o, 0);
    #10 rst_n = 1;
    tick();
    chk("mr_after_valid", bus_req_valid_o, 0);
    chk("mr_after_busy", ld_busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
